// File: rtl/link_pkg.sv
// link_pkg
//   Shared types and helpers for the load-link / store-conditional
//   reservation unit (link_monitor and link_entry).
//
//   Contents:
//     LINK_DEF_*     default configuration constants
//     link_addr_t    container for a stored granule address (zero-extended)
//     link_entry_t   per-channel reservation state {valid, addr, cnt}
//     link_match()   granule compare of two addresses
//
//   Configuration macro: LINK_TIMEOUT_EN adds the age counter field to
//   link_entry_t; without it the struct carries no counter at all.
package link_pkg;

  localparam int LINK_DEF_BITS      = 32;
  localparam int LINK_DEF_CHANNELS  = 2;
  localparam int LINK_DEF_GRAN_BITS = 0;
  localparam int LINK_DEF_TIMEOUT   = 16;

  // Fixed-width containers so the struct can live in a package. The
  // unused high bits are always zero and are trimmed by synthesis.
  localparam int LINK_ADDR_MAX = 64;
  localparam int LINK_CNT_MAX  = 16;

  typedef logic [LINK_ADDR_MAX-1:0] link_addr_t;

  typedef struct packed {
    logic                    valid;
    link_addr_t              addr;
`ifdef LINK_TIMEOUT_EN
    logic [LINK_CNT_MAX-1:0] cnt;
`endif
  } link_entry_t;

  // Two addresses belong to the same reservation granule when they agree
  // above the low gran_bits bits.
  function automatic logic link_match(input link_addr_t a,
                                      input link_addr_t b,
                                      input int         gran_bits);
    return (a >> gran_bits) == (b >> gran_bits);
  endfunction

endpackage

// File: rtl/link_entry.sv
// link_entry
//   One reservation slot. Holds the valid bit, the reserved granule
//   address and (with LINK_TIMEOUT_EN) an age down-counter.
//
//   Ports:
//     clk, rst_   clock, asynchronous active-low reset
//     set         load-link on this channel: arm and capture load_addr
//     clear       store-conditional issued by this channel
//     snoop       store or foreign successful SC hit this granule
//     load_addr   granule address to capture on set
//     valid       registered reservation valid
//     addr        registered reservation granule address
//
//   Configuration macro: LINK_TIMEOUT_EN enables the TIMEOUT parameter and
//   the expiry counter.
module link_entry
  import link_pkg::*;
`ifdef LINK_TIMEOUT_EN
#(
  parameter int TIMEOUT = LINK_DEF_TIMEOUT
)
`endif
(
  input  logic       clk,
  input  logic       rst_,
  input  logic       set,
  input  logic       clear,
  input  logic       snoop,
  input  link_addr_t load_addr,
  output logic       valid,
  output link_addr_t addr
);

  link_entry_t entry_q;
  link_entry_t entry_d;

  // Update order: invalidations first, then expiry, then the load-link,
  // so an LL always re-arms its own slot regardless of same-cycle kills.
  always_comb begin
    entry_d = entry_q;
    if (clear || snoop) begin
      entry_d.valid = 1'b0;
`ifdef LINK_TIMEOUT_EN
      entry_d.cnt   = '0;
`endif
    end
`ifdef LINK_TIMEOUT_EN
    else if (entry_q.valid) begin
      // The edge seen with a count of 1 is the last one the slot lives through.
      if (entry_q.cnt == LINK_CNT_MAX'(1)) begin
        entry_d.valid = 1'b0;
        entry_d.cnt   = '0;
      end else begin
        entry_d.cnt = entry_q.cnt - LINK_CNT_MAX'(1);
      end
    end
`endif
    if (set) begin
      entry_d.valid = 1'b1;
      entry_d.addr  = load_addr;
`ifdef LINK_TIMEOUT_EN
      entry_d.cnt   = LINK_CNT_MAX'(TIMEOUT);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign valid = entry_q.valid;
  assign addr  = entry_q.addr;

endmodule

// File: rtl/link_monitor.sv
// link_monitor
//   Multi-channel load-link / store-conditional reservation unit for the
//   MEM stage. Keeps one reservation per channel and resolves SC requests
//   in the same cycle.
//
//   Parameters: BITS (address/data width), CHANNELS (reservations),
//   GRAN_BITS (ignored low address bits), TIMEOUT (reservation lifetime,
//   only with LINK_TIMEOUT_EN). CH_W is derived.
//
//   Ports:
//     clk, rst_            clock, asynchronous active-low reset
//     ll_valid/ll_ch/ll_addr   load-link request
//     sc_valid/sc_ch/sc_addr   store-conditional request
//     st_valid/st_addr         ordinary store from any channel
//     sc_ok                SC succeeds (combinational)
//     sc_wr_               active-low data-memory write strobe for the SC
//     sc_rdata             register writeback {zeros, sc_ok}
//     link_valid           registered per-channel reservation valid
//
//   Configuration macro: LINK_TIMEOUT_EN makes reservations expire
//   TIMEOUT cycles after their load-link.
module link_monitor
  import link_pkg::*;
#(
  parameter int  BITS      = LINK_DEF_BITS,
  parameter int  CHANNELS  = LINK_DEF_CHANNELS,
  parameter int  GRAN_BITS = LINK_DEF_GRAN_BITS,
  parameter int  TIMEOUT   = LINK_DEF_TIMEOUT,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)
(
  input  logic                clk,
  input  logic                rst_,
  input  logic                ll_valid,
  input  logic [CH_W-1:0]     ll_ch,
  input  logic [BITS-1:0]     ll_addr,
  input  logic                sc_valid,
  input  logic [CH_W-1:0]     sc_ch,
  input  logic [BITS-1:0]     sc_addr,
  input  logic                st_valid,
  input  logic [BITS-1:0]     st_addr,
  output logic                sc_ok,
  output logic                sc_wr_,
  output logic [BITS-1:0]     sc_rdata,
  output logic [CHANNELS-1:0] link_valid
);

  if (CHANNELS < 1 || TIMEOUT < 1 || BITS > LINK_ADDR_MAX || GRAN_BITS >= BITS) begin : g_bad_params
    $error("link_monitor: illegal parameter combination");
  end

  link_addr_t ll_wide;
  link_addr_t sc_wide;
  link_addr_t st_wide;
  link_addr_t ll_gran;
  link_addr_t sc_gran;
  link_addr_t st_gran;

  link_addr_t          entry_addr [CHANNELS];
  logic [CHANNELS-1:0] entry_valid;
  logic [CHANNELS-1:0] ll_sel;
  logic [CHANNELS-1:0] sc_sel;
  logic [CHANNELS-1:0] match_sc;
  logic [CHANNELS-1:0] match_st;
  logic [CHANNELS-1:0] snoop;
  logic                st_kills_sc;
  logic                sc_pass;

  assign ll_wide = LINK_ADDR_MAX'(ll_addr);
  assign sc_wide = LINK_ADDR_MAX'(sc_addr);
  assign st_wide = LINK_ADDR_MAX'(st_addr);

  // Stored addresses are already granule-aligned, so compare against the
  // shifted request addresses with no further masking.
  assign ll_gran = ll_wide >> GRAN_BITS;
  assign sc_gran = sc_wide >> GRAN_BITS;
  assign st_gran = st_wide >> GRAN_BITS;

  // One-hot channel decode. An index with no matching channel selects
  // nothing, which is how out-of-range requests are dropped.
  always_comb begin
    ll_sel   = '0;
    sc_sel   = '0;
    match_sc = '0;
    match_st = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ll_sel[c]   = ll_valid && (ll_ch == CH_W'(c));
      sc_sel[c]   = sc_valid && (sc_ch == CH_W'(c));
      match_sc[c] = link_match(entry_addr[c], sc_gran, 0);
      match_st[c] = link_match(entry_addr[c], st_gran, 0);
    end
  end

  // A same-cycle ordinary store to the granule is ordered ahead of the SC.
  assign st_kills_sc = st_valid && link_match(st_wide, sc_wide, GRAN_BITS);
  assign sc_pass     = (|(sc_sel & entry_valid & match_sc)) && !st_kills_sc;

  // The issuing channel is handled by its own clear input; snoop covers
  // stores (issuer included) and other channels hit by a successful SC.
  always_comb begin
    snoop = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      snoop[c] = (st_valid && match_st[c]) ||
                 (sc_pass && !sc_sel[c] && match_sc[c]);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_entry
`ifdef LINK_TIMEOUT_EN
    link_entry #(
      .TIMEOUT (TIMEOUT)
    ) u_entry (
      .clk       (clk),
      .rst_      (rst_),
      .set       (ll_sel[c]),
      .clear     (sc_sel[c]),
      .snoop     (snoop[c]),
      .load_addr (ll_gran),
      .valid     (entry_valid[c]),
      .addr      (entry_addr[c])
    );
`else
    link_entry u_entry (
      .clk       (clk),
      .rst_      (rst_),
      .set       (ll_sel[c]),
      .clear     (sc_sel[c]),
      .snoop     (snoop[c]),
      .load_addr (ll_gran),
      .valid     (entry_valid[c]),
      .addr      (entry_addr[c])
    );
`endif
  end

  assign sc_ok      = sc_pass;
  assign sc_wr_     = ~sc_pass;
  assign sc_rdata   = BITS'(sc_pass);
  assign link_valid = entry_valid;

endmodule

// File: tb/tb_link_monitor.sv
// tb_link_monitor
//   Directed bench for link_monitor: three channels (so index 3 is out of
//   range), 4-word granules and TIMEOUT=4. Each step drives one cycle of
//   requests, checks the same-cycle SC outputs plus the registered
//   link_valid, then advances one clock.
module tb_link_monitor;

  localparam int BITS      = 32;
  localparam int CHANNELS  = 3;
  localparam int GRAN_BITS = 2;
  localparam int TIMEOUT   = 4;
  localparam int CH_W      = 2;

  logic                clk = 1'b0;
  logic                rst_;
  logic                ll_valid;
  logic [CH_W-1:0]     ll_ch;
  logic [BITS-1:0]     ll_addr;
  logic                sc_valid;
  logic [CH_W-1:0]     sc_ch;
  logic [BITS-1:0]     sc_addr;
  logic                st_valid;
  logic [BITS-1:0]     st_addr;
  logic                sc_ok;
  logic                sc_wr_;
  logic [BITS-1:0]     sc_rdata;
  logic [CHANNELS-1:0] link_valid;

  int total = 0;
  int bad   = 0;

  link_monitor #(
    .BITS      (BITS),
    .CHANNELS  (CHANNELS),
    .GRAN_BITS (GRAN_BITS),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .ll_valid   (ll_valid),
    .ll_ch      (ll_ch),
    .ll_addr    (ll_addr),
    .sc_valid   (sc_valid),
    .sc_ch      (sc_ch),
    .sc_addr    (sc_addr),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .sc_ok      (sc_ok),
    .sc_wr_     (sc_wr_),
    .sc_rdata   (sc_rdata),
    .link_valid (link_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the end of the sequence");
    $fatal(1, "[TB] watchdog");
  end

  task automatic apply_stimulus(input logic llv, input logic [CH_W-1:0] llc, input logic [BITS-1:0] lla,
                                input logic scv, input logic [CH_W-1:0] scc, input logic [BITS-1:0] sca,
                                input logic stv, input logic [BITS-1:0] sta);
    ll_valid = llv;
    ll_ch    = llc;
    ll_addr  = lla;
    sc_valid = scv;
    sc_ch    = scc;
    sc_addr  = sca;
    st_valid = stv;
    st_addr  = sta;
  endtask

  task automatic check_output(input string tag, input logic exp_ok, input logic [CHANNELS-1:0] exp_lv);
    logic [BITS-1:0] exp_rdata;
    exp_rdata = {{(BITS-1){1'b0}}, exp_ok};
    total++;
    assert (sc_ok === exp_ok) else begin
      bad++;
      $error("[TB] FAIL %s sc_ok got=%0b exp=%0b", tag, sc_ok, exp_ok);
    end
    total++;
    assert (sc_wr_ === ~exp_ok) else begin
      bad++;
      $error("[TB] FAIL %s sc_wr_ got=%0b exp=%0b", tag, sc_wr_, ~exp_ok);
    end
    total++;
    assert (sc_rdata === exp_rdata) else begin
      bad++;
      $error("[TB] FAIL %s sc_rdata got=%h exp=%h", tag, sc_rdata, exp_rdata);
    end
    total++;
    assert (link_valid === exp_lv) else begin
      bad++;
      $error("[TB] FAIL %s link_valid got=%b exp=%b", tag, link_valid, exp_lv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag,
                      input logic llv, input logic [CH_W-1:0] llc, input logic [BITS-1:0] lla,
                      input logic scv, input logic [CH_W-1:0] scc, input logic [BITS-1:0] sca,
                      input logic stv, input logic [BITS-1:0] sta,
                      input logic exp_ok, input logic [CHANNELS-1:0] exp_lv);
    apply_stimulus(llv, llc, lla, scv, scc, sca, stv, sta);
    #1;
    check_output(tag, exp_ok, exp_lv);
    tick();
  endtask

  initial begin
    rst_ = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 0, 3'b000);
    rst_ = 1'b1;
    #1;

    $display("[TB] basic LL/SC");
    step("sc_after_reset",   0,0,32'h000, 1,0,32'h100, 0,32'h000, 0, 3'b000);
    step("ll0",              1,0,32'h100, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("sc0_pass",         0,0,32'h000, 1,0,32'h100, 0,32'h000, 1, 3'b001);
    step("sc0_again",        0,0,32'h000, 1,0,32'h100, 0,32'h000, 0, 3'b000);

    $display("[TB] foreign SC invalidation");
    step("ll0_b",            1,0,32'h100, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("ll1",              1,1,32'h100, 0,0,32'h000, 0,32'h000, 0, 3'b001);
    step("sc1_pass",         0,0,32'h000, 1,1,32'h100, 0,32'h000, 1, 3'b011);
    step("sc0_after_foreign",0,0,32'h000, 1,0,32'h100, 0,32'h000, 0, 3'b000);

    $display("[TB] store snoop and granules");
    step("ll0_gran",         1,0,32'h100, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("st_103",           0,0,32'h000, 0,0,32'h000, 1,32'h103, 0, 3'b001);
    step("sc_after_st103",   0,0,32'h000, 1,0,32'h100, 0,32'h000, 0, 3'b000);
    step("ll0_gran2",        1,0,32'h100, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("st_104",           0,0,32'h000, 0,0,32'h000, 1,32'h104, 0, 3'b001);
    step("sc_after_st104",   0,0,32'h000, 1,0,32'h100, 0,32'h000, 1, 3'b001);

    $display("[TB] same-cycle ordering");
    step("ll0_200",          1,0,32'h200, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("st_sc_same",       0,0,32'h000, 1,0,32'h200, 1,32'h200, 0, 3'b001);
    step("st_ll1_same",      1,1,32'h200, 0,0,32'h000, 1,32'h200, 0, 3'b000);
    step("after_st_ll",      0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b010);
    step("sc_gran_alias",    0,0,32'h000, 1,1,32'h201, 0,32'h000, 1, 3'b010);
    step("ll_sc_same_ch",    1,0,32'h300, 1,0,32'h300, 0,32'h000, 0, 3'b000);
    step("sc_wrong_addr",    0,0,32'h000, 1,0,32'h310, 0,32'h000, 0, 3'b001);

    $display("[TB] out-of-range channel");
    step("ll2_300",          1,2,32'h300, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("ll3_oor",          1,3,32'h300, 0,0,32'h000, 0,32'h000, 0, 3'b100);
    step("sc3_oor",          0,0,32'h000, 1,3,32'h300, 0,32'h000, 0, 3'b100);
    step("sc2_pass",         0,0,32'h000, 1,2,32'h300, 0,32'h000, 1, 3'b100);
    step("idle_a",           0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b000);

    $display("[TB] LL reload and selective clears");
    step("ll1_400",          1,1,32'h400, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("ll1_500_sc1_400",  1,1,32'h500, 1,1,32'h400, 0,32'h000, 1, 3'b010);
    step("sc1_500",          0,0,32'h000, 1,1,32'h500, 0,32'h000, 1, 3'b010);
    step("idle_b",           0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("ll0_600",          1,0,32'h600, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    step("ll1_700",          1,1,32'h700, 0,0,32'h000, 0,32'h000, 0, 3'b001);
    step("sc1_700",          0,0,32'h000, 1,1,32'h700, 0,32'h000, 1, 3'b011);
    step("idle_c",           0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b001);
    step("st_604",           0,0,32'h000, 0,0,32'h000, 1,32'h604, 0, 3'b001);
    step("st_602",           0,0,32'h000, 0,0,32'h000, 1,32'h602, 0, 3'b001);
    step("idle_d",           0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b000);

`ifdef LINK_TIMEOUT_EN
    $display("[TB] reservation timeout");
    step("to_ll_a",          1,0,32'h800, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    for (int i = 1; i < TIMEOUT; i++) begin
      step($sformatf("to_live_a%0d", i), 0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b001);
    end
    step("to_sc_last",       0,0,32'h000, 1,0,32'h800, 0,32'h000, 1, 3'b001);
    step("to_ll_b",          1,0,32'h800, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    for (int i = 1; i <= TIMEOUT; i++) begin
      step($sformatf("to_live_b%0d", i), 0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b001);
    end
    step("to_sc_expired",    0,0,32'h000, 1,0,32'h800, 0,32'h000, 0, 3'b000);
    step("to_idle",          0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b000);
`else
    $display("[TB] reservation persistence");
    step("keep_ll",          1,0,32'h800, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("keep_live%0d", i), 0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b001);
    end
    step("keep_sc",          0,0,32'h000, 1,0,32'h800, 0,32'h000, 1, 3'b001);
    step("keep_idle",        0,0,32'h000, 0,0,32'h000, 0,32'h000, 0, 3'b000);
`endif

    $display("[TB] asynchronous reset");
    step("rst_ll0",          1,0,32'h900, 0,0,32'h000, 0,32'h000, 0, 3'b000);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_output("pre_reset", 0, 3'b001);
    rst_ = 1'b0;
    #1;
    check_output("async_reset", 0, 3'b000);
    rst_ = 1'b1;
    #1;
    step("sc_after_rst",     0,0,32'h000, 1,0,32'h900, 0,32'h000, 0, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_monitor.md
# link_monitor

Multi-channel load-link / store-conditional reservation unit for the pipelined CPU data path. It keeps one reservation (valid bit, granule address and optional age counter) per requesting channel, such as hardware threads or cores sharing one data memory. It resolves store-conditional requests in the same cycle, returning the success flag, the data-memory write strobe and the register-file result word. It sits beside the data memory in the MEM stage and is fed by the EX/MEM pipeline register.

## Interface
- BITS, 32, address/data width
- CHANNELS, 2, number of independent reservations (>=1)
- GRAN_BITS, 0, low address bits ignored in matching (reservation granule = 2^GRAN_BITS words)
- TIMEOUT, 16, reservation lifetime in cycles (>=1; used only with LINK_TIMEOUT_EN)
- CH_W = $clog2(CHANNELS) (min 1), derived localparam

- clk  in  1  system clock
- rst_  in  1  reset; asynchronous, active-low
- ll_valid  in  1  load-link request this cycle
- ll_ch  in  CH_W  channel issuing the load-link
- ll_addr  in  BITS  load-link address (alu_out)
- sc_valid  in  1  store-conditional request this cycle
- sc_ch  in  CH_W  channel issuing the store-conditional
- sc_addr  in  BITS  store-conditional address
- st_valid  in  1  ordinary store (any channel) this cycle
- st_addr  in  BITS  ordinary store address
- sc_ok  out  1  store-conditional succeeds (combinational)
- sc_wr_  out  1  active-low data-memory write strobe for the SC
- sc_rdata  out  BITS  register writeback value {zeros, sc_ok}
- link_valid  out  CHANNELS  registered per-channel reservation valid

## Operation
- Match: two addresses match when a[BITS-1:GRAN_BITS] == b[BITS-1:GRAN_BITS]. Stored address is BITS-GRAN_BITS wide.
- sc_ok = sc_valid & valid[sc_ch] & match(addr[sc_ch], sc_addr) & ~(st_valid & match(st_addr, sc_addr)). A same-cycle ordinary store to the granule is ordered first and kills the SC.
- sc_wr_ = ~sc_ok. When sc_valid=0, sc_ok=0, sc_wr_=1 and sc_rdata=0.
- Each clock edge updates the per-channel state in the following order; later steps win:
  1. Ordinary store: st_valid clears valid[c] for every c whose addr matches st_addr, including the issuer.
  2. SC effects: sc_valid clears valid[sc_ch], whether the SC passes or fails. A successful SC also clears valid[c] of every other channel matching sc_addr.
  3. Timeout expiry (macro only).
  4. Load-link: ll_valid sets valid[ll_ch]=1 and addr[ll_ch]=ll_addr granule, and reloads the counter. LL therefore wins over any same-cycle invalidation of its own channel.
- An LL and an SC on the same channel in the same cycle: the SC is evaluated against the old state and the entry ends up reloaded by the LL.
- Out-of-range channel index (>= CHANNELS): the request is ignored, and an SC fails.
- Reset mid-operation: all reservations drop immediately, asynchronously. The first SC after reset deassertion fails.

## Timing
- Reset values: link_valid=0, stored addresses=0, counters=0. With inputs idle: sc_ok=0, sc_wr_=1, sc_rdata=0.
- LL in cycle n sets link_valid[c]=1 from cycle n+1. An SC in cycle n+1 can succeed.
- SC result is zero-latency (same cycle). The SC's clear appears on link_valid at n+1.
- Store invalidation in cycle n clears link_valid from n+1. Its effect on a same-cycle SC is combinational.
- With timeout: link_valid is high during cycles n+1 through n+TIMEOUT, and low from n+TIMEOUT+1 unless re-armed. The counter loads TIMEOUT on LL and decrements each edge while valid. The edge at which the count is 1 clears valid.

## Configuration
- LINK_TIMEOUT_EN defined:
  - per-channel down-counter of $clog2(TIMEOUT+1) bits;
  - reservations expire as described under Timing;
  - counter is forced to 0 whenever valid clears by any other cause.
- Undefined: no counters are synthesised, and reservations persist until cleared by an SC, a store, a new LL or reset. TIMEOUT is ignored.

## Structure
- Shared package link_pkg holds:
  - link_entry_t struct {valid, addr granule, cnt};
  - function link_match(a, b, gran_bits);
  - default constants for CHANNELS, GRAN_BITS and TIMEOUT.
- Sub-module link_entry is generated once per channel. Its inputs are set (LL), clear (own SC), snoop (store or foreign successful SC) and the load address; it outputs valid and addr.
- The top level contains the channel decode, the combinational SC resolve and the output muxing.

## Test plan
- Reset, then SC ch0 at 0x100: sc_ok=0, sc_wr_=1, sc_rdata=0.
- LL ch0 at 0x100, SC ch0 at 0x100 next cycle: sc_ok=1, sc_wr_=0, sc_rdata=1, and link_valid[0]=0 afterwards. A second SC at 0x100 fails.
- LL ch0 at 0x100, LL ch1 at 0x100, then SC ch1 at 0x100 succeeds: link_valid=2'b00, and a following SC ch0 at 0x100 fails.
- GRAN_BITS=2: LL ch0 at 0x100, store at 0x103 → link_valid[0]=0 and the SC fails. LL again, store at 0x104 → the SC succeeds.
- Same-cycle store 0x200 plus SC ch0 0x200 after LL ch0 0x200: sc_ok=0. Same-cycle store 0x200 plus LL ch1 0x200: link_valid[1]=1.
- LINK_TIMEOUT_EN with TIMEOUT=4: LL in cycle 10. An SC in cycle 14 succeeds; after re-LL in cycle 20, an SC in cycle 25 fails with link_valid low from cycle 25.
